// File: rtl/mmio_board_bank.sv
// Memory-mapped I/O front end for the checkers CPU data port: status, board
// registers, a debounced sensor board with sticky change event, and RAM pass-through.
module mmio_board_bank #(
    parameter int          DATA_W     = 32,
    parameter int          NUM_BOARDS = 3,
    parameter logic [15:0] BASE_ADDR  = 16'h1000,
    parameter int          DEBOUNCE   = 4,
    parameter int          RAM_AW     = 12
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wEn,
    input  logic [31:0]                  addr,
    input  logic [DATA_W-1:0]            dataIn,
    output logic [DATA_W-1:0]            dataOut,
    output logic [NUM_BOARDS*DATA_W-1:0] boardsOut,
    output logic [DATA_W-1:0]            statusOut,
    input  logic [DATA_W-1:0]            sensorBoardIn,
    output logic [DATA_W-1:0]            sensorBoardOut,
    output logic                         sensorIrq,
    output logic                         ramWEn,
    output logic [RAM_AW-1:0]            ramAddr,
    input  logic [DATA_W-1:0]            ramDataIn
);

    localparam int CNT_W = $clog2(DEBOUNCE) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);
    localparam logic [31:0] OFF_STATUS = 32'd0;
    localparam logic [31:0] OFF_SENSOR = 32'd1;
    localparam logic [31:0] OFF_EVT    = 32'(NUM_BOARDS + 2);
    localparam logic [31:0] OFF_MASK   = 32'(NUM_BOARDS + 3);

    logic [DATA_W-1:0] status_q, status_d;
    logic [DATA_W-1:0] board_q [NUM_BOARDS];
    logic [DATA_W-1:0] board_d [NUM_BOARDS];
    logic [DATA_W-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [DATA_W-1:0] cand_q, cand_d, stable_q, stable_d, mask_q, mask_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              event_q, event_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic              ram_sel_q, ram_sel_d;

    logic [31:0]       offset_s;
    logic              mmio_hit_s, ram_hit_s, wr_s, set_evt_s, clr_evt_s;
    logic [DATA_W-1:0] set_bits_s, clr_bits_s;

    // Address decode; anything past the mask offset (or below BASE_ADDR, which wraps) misses.
    always_comb begin
        offset_s   = addr - {16'h0000, BASE_ADDR};
        mmio_hit_s = (addr[31:16] == 16'h0000) && (offset_s <= OFF_MASK);
        ram_hit_s  = ((addr >> RAM_AW) == 32'd0) && !mmio_hit_s;
        wr_s       = wEn && mmio_hit_s;
        ramWEn     = wEn && ram_hit_s;
        ramAddr    = addr[RAM_AW-1:0];
    end

    // Sensor synchronizer and debouncer; the counter saturates at DEBOUNCE-1.
    always_comb begin
        sync1_d    = sensorBoardIn;
        sync2_d    = sync1_q;
        cand_d     = cand_q;
        cnt_d      = cnt_q;
        stable_d   = stable_q;
        set_bits_s = '0;
        set_evt_s  = 1'b0;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == CNT_MAX) begin
            if (cand_q != stable_q) begin
                stable_d   = cand_q;
                set_bits_s = stable_q ^ cand_q;
                set_evt_s  = 1'b1;
            end else begin
                stable_d = stable_q;
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Register writes; new sensor changes take priority over write-1-to-clear.
    always_comb begin
        status_d = status_q;
        board_d  = board_q;
        if (wr_s && (offset_s == OFF_STATUS)) begin
            status_d = dataIn;
        end else begin
            status_d = status_q;
        end
        for (int k = 0; k < NUM_BOARDS; k++) begin
            if (wr_s && (offset_s == 32'(k + 2))) begin
                board_d[k] = dataIn;
            end else begin
                board_d[k] = board_q[k];
            end
        end
        clr_evt_s  = wr_s && (offset_s == OFF_EVT) && dataIn[0];
        clr_bits_s = (wr_s && (offset_s == OFF_MASK)) ? dataIn : '0;
        event_d    = (event_q && !clr_evt_s) || set_evt_s;
        mask_d     = (mask_q & ~clr_bits_s) | set_bits_s;
    end

    // Read mux sampled from pre-write register values.
    always_comb begin
        rd_d      = '0;
        ram_sel_d = ram_hit_s;
        if (mmio_hit_s) begin
            case (offset_s)
                OFF_STATUS: rd_d = status_q;
                OFF_SENSOR: rd_d = stable_q;
                OFF_EVT:    rd_d = {{(DATA_W-1){1'b0}}, event_q};
                OFF_MASK:   rd_d = mask_q;
                default: begin
                    for (int k = 0; k < NUM_BOARDS; k++) begin
                        if (offset_s == 32'(k + 2)) begin
                            rd_d = board_q[k];
                        end else begin
                            rd_d = rd_d;
                        end
                    end
                end
            endcase
        end else begin
            rd_d = '0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            status_q  <= '0;
            for (int k = 0; k < NUM_BOARDS; k++) board_q[k] <= '0;
            sync1_q   <= '0;
            sync2_q   <= '0;
            cand_q    <= '0;
            cnt_q     <= '0;
            stable_q  <= '0;
            event_q   <= 1'b0;
            mask_q    <= '0;
            rd_q      <= '0;
            ram_sel_q <= 1'b0;
        end else begin
            status_q  <= status_d;
            board_q   <= board_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            event_q   <= event_d;
            mask_q    <= mask_d;
            rd_q      <= rd_d;
            ram_sel_q <= ram_sel_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_BOARDS; g++) begin : g_boards
            assign boardsOut[g*DATA_W +: DATA_W] = board_q[g];
        end
    endgenerate

    // RAM data already carries its own one-cycle latency, so only the select is registered.
    assign dataOut        = ram_sel_q ? ramDataIn : rd_q;
    assign statusOut      = status_q;
    assign sensorBoardOut = stable_q;
    assign sensorIrq      = event_q && status_q[DATA_W-1];

endmodule

// File: tb/tb_mmio_board_bank.sv
// Directed self-checking bench for mmio_board_bank with a small synchronous RAM model.
module tb_mmio_board_bank;

    logic        clock = 1'b0;
    logic        reset, wEn;
    logic [31:0] addr, dataIn, dataOut, statusOut, sensorBoardIn, sensorBoardOut;
    logic [95:0] boardsOut;
    logic        sensorIrq, ramWEn;
    logic [11:0] ramAddr;
    logic [31:0] ramDataIn;
    logic [31:0] tb_mem [0:4095];

    int n_checks = 0;
    int n_errors = 0;

    mmio_board_bank dut (
        .clock(clock), .reset(reset), .wEn(wEn), .addr(addr), .dataIn(dataIn),
        .dataOut(dataOut), .boardsOut(boardsOut), .statusOut(statusOut),
        .sensorBoardIn(sensorBoardIn), .sensorBoardOut(sensorBoardOut),
        .sensorIrq(sensorIrq), .ramWEn(ramWEn), .ramAddr(ramAddr), .ramDataIn(ramDataIn)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (ramWEn) tb_mem[ramAddr] <= dataIn;
        ramDataIn <= tb_mem[ramAddr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wEn = 1'b1; addr = a; dataIn = d;
        tick();
        wEn = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        wEn = 1'b0; addr = a;
        tick();
        check_eq(tag, dataOut, exp);
    endtask

    initial begin
        reset = 1'b1; wEn = 1'b0; addr = 32'h0; dataIn = 32'h0; sensorBoardIn = 32'h0;
        ticks(2);
        check_eq("rst_dataOut", dataOut, 32'h0);
        check_eq("rst_irq", {31'h0, sensorIrq}, 32'h0);
        check_eq("rst_sensor", sensorBoardOut, 32'h0);
        check_eq("rst_status", statusOut, 32'h0);
        reset = 1'b0;
        tick();

        // Board writes and readback
        wEn = 1'b1; addr = 32'h1002; dataIn = 32'hA5A5_0001;
        #1 check_eq("mmio_no_ramwen", {31'h0, ramWEn}, 32'h0);
        tick();
        wr(32'h1004, 32'h0000_00FF);
        rd_chk("rd_board0", 32'h1002, 32'hA5A5_0001);
        rd_chk("rd_board2", 32'h1004, 32'h0000_00FF);
        check_eq("boardsOut0", boardsOut[31:0], 32'hA5A5_0001);
        check_eq("boardsOut2", boardsOut[95:64], 32'h0000_00FF);
        check_eq("boardsOut1", boardsOut[63:32], 32'h0);

        // Short glitch never reaches the stable board
        sensorBoardIn = 32'h1;
        ticks(4);
        sensorBoardIn = 32'h0;
        ticks(10);
        check_eq("glitch_sensor", sensorBoardOut, 32'h0);
        rd_chk("glitch_event", 32'h1005, 32'h0);
        rd_chk("glitch_mask", 32'h1006, 32'h0);

        // Held change appears exactly 7 edges later
        sensorBoardIn = 32'h0000_0010;
        ticks(6);
        check_eq("deb_before", sensorBoardOut, 32'h0);
        tick();
        check_eq("deb_after", sensorBoardOut, 32'h0000_0010);
        rd_chk("deb_event", 32'h1005, 32'h1);
        rd_chk("deb_mask", 32'h1006, 32'h10);
        rd_chk("rd_sensor", 32'h1001, 32'h10);
        check_eq("irq_masked", {31'h0, sensorIrq}, 32'h0);
        wr(32'h1000, 32'h8000_0000);
        check_eq("irq_on", {31'h0, sensorIrq}, 32'h1);

        // Clear coincides with a newly accepted change: set wins
        sensorBoardIn = 32'h0000_0030;
        ticks(6);
        wr(32'h1005, 32'h1);
        check_eq("set_win_sensor", sensorBoardOut, 32'h30);
        rd_chk("set_win_event", 32'h1005, 32'h1);
        rd_chk("set_win_mask", 32'h1006, 32'h30);
        check_eq("irq_still", {31'h0, sensorIrq}, 32'h1);
        wr(32'h1005, 32'h1);
        check_eq("irq_fall", {31'h0, sensorIrq}, 32'h0);
        rd_chk("evt_cleared", 32'h1005, 32'h0);
        wr(32'h1006, 32'h10);
        rd_chk("mask_partial_clr", 32'h1006, 32'h20);

        // RAM pass-through, unmapped and read-only addresses
        wEn = 1'b1; addr = 32'h0000_0010; dataIn = 32'h1234;
        #1;
        check_eq("ram_wen", {31'h0, ramWEn}, 32'h1);
        check_eq("ram_addr", {20'h0, ramAddr}, 32'h010);
        tick();
        wEn = 1'b0;
        rd_chk("ram_rd", 32'h0000_0010, 32'h1234);
        wEn = 1'b1; addr = 32'h1008; dataIn = 32'hFFFF_FFFF;
        #1 check_eq("unmapped_no_ramwen", {31'h0, ramWEn}, 32'h0);
        tick();
        wEn = 1'b0;
        rd_chk("unmapped_rd", 32'h1008, 32'h0);
        rd_chk("high_addr_rd", 32'h0001_1000, 32'h0);
        wr(32'h1001, 32'hFFFF_FFFF);
        check_eq("ro_sensor", sensorBoardOut, 32'h30);
        rd_chk("ro_sensor_rd", 32'h1001, 32'h30);

        // Same-cycle write and read returns the old value
        wr(32'h1003, 32'h5555_AAAA);
        check_eq("pre_write_rd", dataOut, 32'h0);
        rd_chk("post_write_rd", 32'h1003, 32'h5555_AAAA);

        // Reset mid-debounce
        sensorBoardIn = 32'h0000_00F0;
        ticks(2);
        reset = 1'b1;
        ticks(2);
        check_eq("mid_rst_dataOut", dataOut, 32'h0);
        check_eq("mid_rst_sensor", sensorBoardOut, 32'h0);
        check_eq("mid_rst_status", statusOut, 32'h0);
        check_eq("mid_rst_board1", boardsOut[63:32], 32'h0);
        check_eq("mid_rst_irq", {31'h0, sensorIrq}, 32'h0);
        reset = 1'b0;
        ticks(6);
        check_eq("post_rst_before", sensorBoardOut, 32'h0);
        tick();
        check_eq("post_rst_after", sensorBoardOut, 32'hF0);
        rd_chk("post_rst_event", 32'h1005, 32'h1);
        rd_chk("post_rst_mask", 32'h1006, 32'hF0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
